// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, default widths
// and the response bundle.
package apb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_req_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_requester.sv
// APB requester: one command in, one APB transfer out, one response
// back, with a bounded wait-state timeout.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    apb_req_state_e state;
    apb_req_state_e next;

    logic [CW-1:0] wcnt;
    logic          accept;
    logic          done;
    logic          tout;

    assign accept = cmd_valid && cmd_ready;
    assign done   = (state == ACCESS) && pready;
    // Timeout only fires while still waiting; a completing pready wins.
    assign tout   = (TIMEOUT > 0) && (state == ACCESS) && !pready
                    && (wcnt == CW'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (accept) next = SETUP;
            SETUP:   next = ACCESS;
            ACCESS:  if (done || tout) next = RESP;
            RESP:    if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = presetn && (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // APB strobes are registered from the next state.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            wcnt        <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            psel    <= (next == SETUP) || (next == ACCESS);
            penable <= (next == ACCESS);
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                wcnt   <= '0;
            end else if (state == ACCESS && !pready && wcnt != '1) begin
                wcnt <= wcnt + 1'b1;
            end
            if (done) begin
                rsp_rdata   <= pwrite ? '0 : prdata;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
            end else if (tout) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: one task per scenario, expected
// values written out by hand.
module tb_apb_requester;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    apb_requester #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        presetn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0abc;
        cmd_wdata = 32'h1111_2222;
        rsp_ready = 1'b1;
        prdata    = 32'h0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({psel, penable, pwrite, rsp_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_ctrl: got %b want 0000",
                     {psel, penable, pwrite, rsp_valid});
        end
        n_tests++;
        if (paddr !== 32'h0 || pwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_addr_data: got %h/%h want 0/0", paddr, pwdata);
        end
        n_tests++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rsp: got %h/%b/%b want 0/0/0",
                     rsp_rdata, rsp_err, rsp_timeout);
        end
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        presetn   = 1'b1;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: got ready=%b psel=%b want 1/0",
                     cmd_ready, psel);
        end
    endtask

    task automatic test_write();
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'hDEAD_BEEF;
        cmd_valid = 1'b1;
        pready    = 1'b1;
        pslverr   = 1'b0;
        prdata    = 32'hFFFF_0000;
        rsp_ready = 1'b1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_c0_ready: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if ({psel, penable, pwrite} !== 3'b101) begin
            n_fail++;
            $display("FAIL wr_c1_ctrl: got %b want 101", {psel, penable, pwrite});
        end
        n_tests++;
        if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wr_c1_addr: got %h/%h want 10/deadbeef", paddr, pwdata);
        end
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_c1_busy: got %b want 0", cmd_ready);
        end
        tick();
        n_tests++;
        if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h10) begin
            n_fail++;
            $display("FAIL wr_c2_access: got %b/%h want 111/10",
                     {psel, penable, pwrite}, paddr);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_c3_rsp: got %b/%h/%b want 1/0/0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        n_tests++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_c3_bus: got %b%b want 00", psel, penable);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_c4_idle: got %b/%b want 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_wait();
        int lat;
        int pen;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h0;
        cmd_valid = 1'b1;
        pready    = 1'b0;
        prdata    = 32'h1234_5678;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        pen = 0;
        while (!rsp_valid && lat < 20) begin
            if (penable) pen++;
            pready = (pen >= 3);
            tick();
            lat++;
        end
        n_tests++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d want 5", lat);
        end
        n_tests++;
        if (pen !== 3) begin
            n_fail++;
            $display("FAIL rd_penable_cycles: got %0d want 3", pen);
        end
        n_tests++;
        if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_rsp: got %h/%b/%b want 12345678/0/0",
                     rsp_rdata, rsp_err, rsp_timeout);
        end
        pready = 1'b1;
        tick();
    endtask

    task automatic test_slverr();
        int lat;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        cmd_valid = 1'b1;
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 32'hA5A5_0F0F;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL err_latency: got %0d want 3", lat);
        end
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL err_rsp: got %b/%b/%h want 1/0/a5a50f0f",
                     rsp_err, rsp_timeout, rsp_rdata);
        end
        pslverr = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int lat;
        int pen;
        cmd_write = 1'b0;
        cmd_addr  = 32'h80;
        cmd_valid = 1'b1;
        pready    = 1'b0;
        prdata    = 32'h7777_8888;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        pen = 0;
        while (!rsp_valid && lat < 30) begin
            if (penable) pen++;
            tick();
            lat++;
        end
        n_tests++;
        if (pen !== 4 || lat !== 6) begin
            n_fail++;
            $display("FAIL to_cycles: got pen=%0d lat=%0d want 4/6", pen, lat);
        end
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL to_rsp: got %b/%b/%h want 1/1/0",
                     rsp_err, rsp_timeout, rsp_rdata);
        end
        n_tests++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL to_bus: got %b%b want 00", psel, penable);
        end
        pready = 1'b1;
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL to_late_ready: got %b/%b want 0/0", rsp_valid, psel);
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        cmd_valid = 1'b1;
        pready    = 1'b1;
        prdata    = 32'hCAFE_0001;
        tick();
        cmd_write = 1'b1;
        cmd_addr  = 32'h44;
        cmd_wdata = 32'h0000_0055;
        tick();
        tick();
        prdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %b/%h/%b want 1/cafe0001/0",
                         i, rsp_valid, rsp_rdata, cmd_ready);
            end
            n_tests++;
            if (paddr !== 32'h40 || psel !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_bus[%0d]: got %h/%b want 40/0", i, paddr, psel);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got %b/%b want 0/1", rsp_valid, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if (psel !== 1'b1 || paddr !== 32'h44 || pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got %b/%h/%b want 1/44/1", psel, paddr, pwrite);
        end
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_second_rsp: got %b/%h want 1/0", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        cmd_write = 1'b1;
        cmd_addr  = 32'h50;
        cmd_wdata = 32'h5050_5050;
        cmd_valid = 1'b1;
        pready    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_tests++;
        if (penable !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_in_access: got %b want 1", penable);
        end
        presetn = 1'b0;
        pready  = 1'b1;
        tick();
        n_tests++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000 || paddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_idle: got %b/%h want 0000/0",
                     {psel, penable, rsp_valid, cmd_ready}, paddr);
        end
        presetn = 1'b1;
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_no_rsp: got %b/%b want 0/1", rsp_valid, cmd_ready);
        end
        cmd_addr  = 32'h60;
        cmd_wdata = 32'h0BAD_F00D;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_tests++;
        if (psel !== 1'b1 || paddr !== 32'h60 || pwdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rm_fresh_setup: got %b/%h/%h want 1/60/0badf00d",
                     psel, paddr, pwdata);
        end
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_fresh_rsp: got %b/%b/%b want 1/0/0",
                     rsp_valid, rsp_err, rsp_timeout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
